// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
package rf_pkg;
  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_NRD   = 2;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);

  typedef logic [DEF_AW-1:0] rf_addr_t;
  typedef logic [DEF_DW-1:0] rf_data_t;

  // LSB of port p in a flat bus of w-bit fields
  function automatic int port_lo(input int p, input int w);
    return p * w;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with reserve/release handshake and flush.
module rf_scoreboard #(
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             sb_clr,
  output logic             rsv_ready,
  output logic [DEPTH-1:0] busy,
  output logic [DEPTH-1:0] busy_nxt
);
  // A write or flush landing this edge frees the slot, so the reservation may reuse it.
  assign rsv_ready = !busy[rsv_addr] || (wr_en && wr_addr == rsv_addr) || sb_clr;

  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_clr)                                            busy_nxt[i] = 1'b0;
      if (wr_en && wr_addr == AW'(i))                        busy_nxt[i] = 1'b0;
      if (rsv_valid && rsv_ready && rsv_addr == AW'(i))      busy_nxt[i] = 1'b1;
      if (ZERO_REG != 0 && i == 0)                           busy_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
endmodule

// File: rtl/rf_multiport.sv
// Parametrised NRD-read / 1-write register file with scoreboard busy bits.
// Define RF_BYPASS_EN for write-through forwarding on same-cycle read/write.
module rf_multiport import rf_pkg::*; #(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NRD-1:0]  rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]  rd_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ready,
  input  logic            sb_clr
);
  logic [DW-1:0]           mem [DEPTH];
  logic [DEPTH-1:0]        busy, busy_nxt;
  logic                    wr_eff;
  logic [NRD-1:0][DW-1:0]  rd_nxt, rd_q;
  logic [NRD-1:0]          bz_nxt, bz_q;

  assign wr_eff = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

  rf_scoreboard #(.DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst(rst),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .sb_clr(sb_clr),
    .rsv_ready(rsv_ready), .busy(busy), .busy_nxt(busy_nxt)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr_eff) mem[wr_addr] <= wr_data;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = rd_addr[port_lo(p, AW) +: AW];
    assign hit = wr_eff && wr_addr == a;
`ifdef RF_BYPASS_EN
    assign rd_nxt[p] = hit ? wr_data : mem[a];
    assign bz_nxt[p] = busy_nxt[a];
`else
    // Read-before-write: a colliding write's busy clear is not yet visible.
    assign rd_nxt[p] = mem[a];
    assign bz_nxt[p] = hit ? busy[a] : busy_nxt[a];
`endif
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q <= '0;
      bz_q <= '0;
    end else begin
      for (int p = 0; p < NRD; p++)
        if (rd_en[p]) begin
          rd_q[p] <= rd_nxt[p];
          bz_q[p] <= bz_nxt[p];
        end
    end

  assign rd_data = rd_q;
  assign rd_busy = bz_q;
endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport (ZERO_REG=1, 2 read ports).
module tb_rf_multiport;
  localparam int DW = 32, DEPTH = 16, AW = 4, NRD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ready;
  logic              sb_clr;

  rf_multiport #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .sb_clr(sb_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int port; logic [DW-1:0] d; logic b; } exp_t;
  exp_t             q[$];
  logic [DW-1:0]    mm [DEPTH];
  logic [DEPTH-1:0] mb;
  logic [DW-1:0]    last_d [NRD];
  logic             last_b [NRD];
  int               n_tst = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tst++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    mb = '0;
    for (int p = 0; p < NRD; p++) begin last_d[p] = '0; last_b[p] = 1'b0; end
    q.delete();
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    rsv_valid = 0; rsv_addr = '0; sb_clr = 0;
  endtask

  task automatic check_outs(input string tag);
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("%s rd_data[%0d]", tag, p), 64'(rd_data[p*DW +: DW]), 64'(last_d[p]));
      chk($sformatf("%s rd_busy[%0d]", tag, p), 64'(rd_busy[p]), 64'(last_b[p]));
    end
  endtask

  // One clock of stimulus; expectations come from the bench model's pre-edge state.
  task automatic cyc(input logic [NRD-1:0] re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic rv, input logic [AW-1:0] ra, input logic clr);
    logic [AW-1:0]    a [NRD];
    logic [DEPTH-1:0] nb;
    logic             rdy, hit, weff;
    exp_t             e;
    @(negedge clk);
    rd_en = re; rd_addr = {a1, a0}; wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_valid = rv; rsv_addr = ra; sb_clr = clr;
    a[0] = a0; a[1] = a1;
    #1;
    rdy = !mb[ra] || (we && wa == ra) || clr;
    chk("rsv_ready", 64'(rsv_ready), 64'(rdy));
    weff = we && wa != '0;
    nb = mb;
    if (clr) nb = '0;
    if (we) nb[wa] = 1'b0;
    if (rv && rdy) nb[ra] = 1'b1;
    nb[0] = 1'b0;
    for (int p = 0; p < NRD; p++)
      if (re[p]) begin
        hit = weff && wa == a[p];
        e.port = p;
`ifdef RF_BYPASS_EN
        e.d = hit ? wd : mm[a[p]];
        e.b = nb[a[p]];
`else
        e.d = mm[a[p]];
        e.b = hit ? mb[a[p]] : nb[a[p]];
`endif
        q.push_back(e);
      end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      last_d[e.port] = e.d;
      last_b[e.port] = e.b;
    end
    if (weff) mm[wa] = wd;
    mb = nb;
    check_outs("cyc");
  endtask

  initial begin
    idle();
    mdl_clear();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 check_outs("por");
    @(negedge clk) rst = 1'b0;

    // write r5, then read it on both ports
    cyc(2'b00, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    cyc(2'b11, 5, 5, 0, 0, 0, 0, 0, 0);
    chk("r5 p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("r5 p1", 64'(rd_data[63:32]), 64'hDEADBEEF);

    // same-cycle write and read of r7
    cyc(2'b01, 7, 0, 1, 7, 32'h1234, 0, 0, 0);
`ifdef RF_BYPASS_EN
    chk("r7 collide", 64'(rd_data[31:0]), 64'h1234);
`else
    chk("r7 collide", 64'(rd_data[31:0]), 64'h0);
`endif

    // reserve r9, read busy, retry blocked, write releases
    cyc(2'b00, 0, 0, 0, 0, 0, 1, 9, 0);
    cyc(2'b10, 0, 9, 0, 0, 0, 0, 0, 0);
    chk("r9 busy", 64'(rd_busy[1]), 64'h1);
    cyc(2'b00, 0, 0, 0, 0, 0, 1, 9, 0);
    chk("r9 retry", 64'(mb[9]), 64'h1);
    cyc(2'b00, 0, 0, 1, 9, 32'h99, 0, 0, 0);
    cyc(2'b01, 9, 0, 0, 0, 0, 0, 0, 0);
    chk("r9 freed", 64'(rd_busy[0]), 64'h0);

    // reserve + write r4 same cycle while busy
    cyc(2'b00, 0, 0, 0, 0, 0, 1, 4, 0);
    cyc(2'b00, 0, 0, 1, 4, 32'hAA, 1, 4, 0);
    cyc(2'b11, 4, 4, 0, 0, 0, 0, 0, 0);
    chk("r4 data", 64'(rd_data[31:0]), 64'hAA);
    chk("r4 busy", 64'(rd_busy[1]), 64'h1);

    // zero register and flush
    cyc(2'b00, 0, 0, 1, 0, 32'hFF, 1, 0, 0);
    cyc(2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0 data", 64'(rd_data[31:0]), 64'h0);
    chk("r0 busy", 64'(rd_busy[0]), 64'h0);
    cyc(2'b00, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 1, 2, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 1, 3, 0);
    cyc(2'b11, 1, 2, 0, 0, 0, 0, 0, 1);
    cyc(2'b01, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("flush r3", 64'(rd_busy[0]), 64'h0);

    // mid-run async reset with r3 busy
    cyc(2'b00, 0, 0, 0, 0, 0, 1, 3, 0);
    cyc(2'b11, 3, 5, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    rsv_addr = 3;
    #2 rst = 1'b1;
    #1;
    mdl_clear();
    check_outs("rst");
    chk("rst rsv_ready", 64'(rsv_ready), 64'h1);
    @(negedge clk) rst = 1'b0;
    cyc(2'b11, 3, 5, 0, 0, 0, 0, 0, 0);

    // random traffic against the model
    for (int n = 0; n < 400; n++)
      cyc(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tst, n_fail);
    $finish;
  end
endmodule
